// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM:
// state codes, supported opcodes and datapath selector encodings.
package mips_ctrl_pkg;

  // Controller states; the codes are visible on the debug state port.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EX   = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

  // Supported opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operand B multiplexor select.
  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  // ALU operation request to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // PC source multiplexor select; 2'b11 is reserved and never driven.
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  // Complete set of datapath controls produced for one state.
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_src;
  } ctrl_out_t;

  // All enables off, all selectors at their zero encoding.
  localparam ctrl_out_t CTRL_NONE = '{
    pc_en:      1'b0,
    iord:       1'b0,
    mem_write:  1'b0,
    ir_write:   1'b0,
    reg_dst:    1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    alu_src_a:  1'b0,
    alu_src_b:  SRCB_REG,
    alu_op:     ALUOP_ADD,
    pc_src:     PCSRC_ALU
  };

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the main control FSM and the multicycle datapath.
// The FSM side uses the master modport, the datapath side the slave one.
interface multicycle_control_fsm_if;

  // Datapath status towards the controller.
  logic [5:0] i_opcode;
  logic       i_zero;
  logic       i_mem_ready;

  // Controls towards the datapath.
  logic       o_pc_en;
  logic       o_iord;
  logic       o_mem_write;
  logic       o_ir_write;
  logic       o_reg_dst;
  logic       o_mem_to_reg;
  logic       o_reg_write;
  logic       o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_alu_op;
  logic [1:0] o_pc_src;
  logic       o_illegal;
  logic [3:0] o_state;

  modport master (
    input  i_opcode, i_zero, i_mem_ready,
    output o_pc_en, o_iord, o_mem_write, o_ir_write, o_reg_dst,
           o_mem_to_reg, o_reg_write, o_alu_src_a, o_alu_src_b,
           o_alu_op, o_pc_src, o_illegal, o_state
  );

  modport slave (
    output i_opcode, i_zero, i_mem_ready,
    input  o_pc_en, o_iord, o_mem_write, o_ir_write, o_reg_dst,
           o_mem_to_reg, o_reg_write, o_alu_src_a, o_alu_src_b,
           o_alu_op, o_pc_src, o_illegal, o_state
  );

endinterface

// File: rtl/control_output_decoder.sv
// Moore output map of the main control FSM. Only the memory handshake
// (FETCH) and the ALU zero flag (BRANCH) reach the outputs directly.
module control_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_e    state_i,
  input  logic      mem_ready_i,
  input  logic      zero_i,
  output ctrl_out_t ctrl_o
);

  // Per-state datapath controls.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves
    // an output unassigned, which would otherwise infer a latch.
    ctrl_o = CTRL_NONE;
    unique case (state_i)
      S_FETCH: begin
        // PC + 4 through the ALU; IR and PC load together once memory answers.
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target: PC + (imm << 2).
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl_o.iord = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        // Strobe stays up through every wait cycle of the store.
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        // Compare A - B; take the target computed in DECODE when equal.
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.pc_en     = zero_i;
      end
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src = PCSRC_JUMP;
        ctrl_o.pc_en  = 1'b1;
      end
      default: begin
        // Unreachable codes look like FETCH with every enable held off.
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath. Holds the state
// register and next-state logic, and forces every output low in reset.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input logic                      i_clk,
  input logic                      i_rst_n,
  multicycle_control_fsm_if.master ctrl
);

  state_e    state_q;
  state_e    state_d;
  logic      illegal;
  ctrl_out_t dec_out;
  ctrl_out_t gated_out;
  logic [3:0] gated_state;
  logic      gated_illegal;

  // State register with synchronous active-low reset into FETCH.
  always_ff @(posedge i_clk) begin
    // NOTE: state updates use non-blocking assignment so every flop
    // samples the pre-edge value regardless of statement order.
    if (!i_rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; unsupported opcodes are flagged in DECODE.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (ctrl.i_mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (ctrl.i_opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        // IR cannot change outside FETCH, so the opcode is still lw or sw.
        state_d = (ctrl.i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        if (ctrl.i_mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        if (ctrl.i_mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: state_d = S_ALU_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  control_output_decoder u_decoder (
    .state_i     (state_q),
    .mem_ready_i (ctrl.i_mem_ready),
    .zero_i      (ctrl.i_zero),
    .ctrl_o      (dec_out)
  );

  // Reset gating: nothing is enabled and the state reads 0 while in reset.
  always_comb begin
    gated_out     = CTRL_NONE;
    gated_state   = 4'd0;
    gated_illegal = 1'b0;
    if (i_rst_n) begin
      gated_out     = dec_out;
      gated_state   = state_q;
      gated_illegal = illegal;
    end
  end

  assign ctrl.o_pc_en      = gated_out.pc_en;
  assign ctrl.o_iord       = gated_out.iord;
  assign ctrl.o_mem_write  = gated_out.mem_write;
  assign ctrl.o_ir_write   = gated_out.ir_write;
  assign ctrl.o_reg_dst    = gated_out.reg_dst;
  assign ctrl.o_mem_to_reg = gated_out.mem_to_reg;
  assign ctrl.o_reg_write  = gated_out.reg_write;
  assign ctrl.o_alu_src_a  = gated_out.alu_src_a;
  assign ctrl.o_alu_src_b  = gated_out.alu_src_b;
  assign ctrl.o_alu_op     = gated_out.alu_op;
  assign ctrl.o_pc_src     = gated_out.pc_src;
  assign ctrl.o_illegal    = gated_illegal;
  assign ctrl.o_state      = gated_state;

endmodule
